mux_rr_nto1_stream: RTL and testbench

Parametrised N-input, W-bit stream multiplexer with a valid/ready handshake and one registered output stage. It generalises the fixed 2:1 and 4:1 select muxes to any channel count, and adds two selection modes: round-robin arbitration, or a forced select.
In the VLIW datapath it merges results from several functional-unit lanes onto one shared consumer, such as a register-file write port or a memory request port. Stalls are handled by backpressure on the handshake instead of by dropping data.

---
 rtl/mux_rr_nto1_stream.sv | 119 +++++++++++
 tb/tb_mux_rr_nto1_stream.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_nto1_stream.sv
// rtl/mux_rr_nto1_stream.sv - N:1 stream mux with round-robin or forced select and one output register
module mux_rr_nto1_stream #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        force_sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src,
    output logic [15:0]             stall_cnt
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_src;
    logic [SEL_W-1:0] r_rr_ptr;
    logic [15:0]      r_stall_cnt;

    logic             w_load_en;
    logic             w_rr_vld;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_fs_vld;
    logic             w_gnt_vld;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_gnt_data;
    logic [SEL_W-1:0] w_next_ptr;

    assign w_load_en = ~r_out_valid | out_ready;

    // Pick the valid channel at the smallest upward distance from the pointer.
    always_comb begin
        int v_best;
        int v_dist;
        w_rr_vld = 1'b0;
        w_rr_idx = '0;
        v_best   = NUM_IN;
        v_dist   = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (i >= int'(r_rr_ptr)) begin
                v_dist = i - int'(r_rr_ptr);
            end else begin
                v_dist = i + NUM_IN - int'(r_rr_ptr);
            end
            if (in_valid[i] && (v_dist < v_best)) begin
                v_best   = v_dist;
                w_rr_vld = 1'b1;
                w_rr_idx = SEL_W'(i);
            end
        end
    end

    // An out-of-range force_sel matches no channel, so no grant is made.
    always_comb begin
        w_fs_vld = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (force_sel == SEL_W'(i)) begin
                w_fs_vld = in_valid[i];
            end
        end
    end

    always_comb begin
        w_gnt_idx = mode ? force_sel : w_rr_idx;
        w_gnt_vld = (mode ? w_fs_vld : w_rr_vld) & ~reset;
        w_xfer    = w_gnt_vld & w_load_en;
    end

    always_comb begin
        w_gnt_data = '0;
        in_ready   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_gnt_idx == SEL_W'(i)) begin
                w_gnt_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = w_xfer;
            end
        end
    end

    assign w_next_ptr = (w_gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : w_gnt_idx + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_rr_ptr    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_gnt_data;
                r_out_src   <= w_gnt_idx;
                r_out_valid <= 1'b1;
                if (!mode) begin
                    r_rr_ptr <= w_next_ptr;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_src   = r_out_src;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mux_rr_nto1_stream.sv
// tb/tb_mux_rr_nto1_stream.sv - directed bench for mux_rr_nto1_stream with NUM_IN=4 and NUM_IN=3 instances
module tb_mux_rr_nto1_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic         rst4, mode4, ordy4, ovld4;
    logic [1:0]   fsel4, osrc4;
    logic [127:0] data4;
    logic [3:0]   vld4, rdy4;
    logic [31:0]  odata4;
    logic [15:0]  stall4;

    logic         rst3, mode3, ordy3, ovld3;
    logic [1:0]   fsel3, osrc3;
    logic [23:0]  data3;
    logic [2:0]   vld3, rdy3;
    logic [7:0]   odata3;
    logic [15:0]  stall3;

    mux_rr_nto1_stream #(.WIDTH(32), .NUM_IN(4)) d4 (
        .clk(clk), .reset(rst4), .mode(mode4), .force_sel(fsel4),
        .in_data(data4), .in_valid(vld4), .in_ready(rdy4),
        .out_data(odata4), .out_valid(ovld4), .out_ready(ordy4),
        .out_src(osrc4), .stall_cnt(stall4)
    );

    mux_rr_nto1_stream #(.WIDTH(8), .NUM_IN(3)) d3 (
        .clk(clk), .reset(rst3), .mode(mode3), .force_sel(fsel3),
        .in_data(data3), .in_valid(vld3), .in_ready(rdy3),
        .out_data(odata3), .out_valid(ovld3), .out_ready(ordy3),
        .out_src(osrc3), .stall_cnt(stall3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst4 = 1'b1; mode4 = 1'b0; ordy4 = 1'b1; vld4 = 4'hF; fsel4 = 2'd0;
        tick();
        checks++; if (ovld4 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ovld4); end
        checks++; if (odata4 !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", odata4); end
        checks++; if (osrc4 !== 2'd0) begin errors++; $display("FAIL reset_src got %0d exp 0", osrc4); end
        checks++; if (stall4 !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall4); end
        checks++; if (rdy4 !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", rdy4); end
        rst4 = 1'b0;
        #1;
        checks++; if (rdy4 !== 4'b0001) begin errors++; $display("FAIL first_grant got %b exp 0001", rdy4); end
    endtask

    task automatic test_rr_stream();
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (ovld4 !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b exp 1", k, ovld4); end
            checks++; if (odata4 !== 32'hA0 + 32'(k % 4)) begin errors++; $display("FAIL rr_data[%0d] got %h exp %h", k, odata4, 32'hA0 + 32'(k % 4)); end
            checks++; if (osrc4 !== 2'(k % 4)) begin errors++; $display("FAIL rr_src[%0d] got %0d exp %0d", k, osrc4, k % 4); end
        end
        vld4 = 4'h0;
        tick();
        checks++; if (ovld4 !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", ovld4); end
        checks++; if (odata4 !== 32'hA3) begin errors++; $display("FAIL rr_drain_hold got %h exp a3", odata4); end
    endtask

    task automatic test_skip_wrap();
        vld4 = 4'b0001;
        tick();
        checks++; if (osrc4 !== 2'd0) begin errors++; $display("FAIL skip_pre got %0d exp 0", osrc4); end
        vld4 = 4'b1001;
        #1;
        checks++; if (rdy4 !== 4'b1000) begin errors++; $display("FAIL skip_ready1 got %b exp 1000", rdy4); end
        tick();
        checks++; if (osrc4 !== 2'd3 || odata4 !== 32'hA3) begin errors++; $display("FAIL skip_src3 got %0d/%h exp 3/a3", osrc4, odata4); end
        checks++; if (rdy4 !== 4'b0001) begin errors++; $display("FAIL wrap_ready got %b exp 0001", rdy4); end
        tick();
        checks++; if (osrc4 !== 2'd0) begin errors++; $display("FAIL wrap_src0 got %0d exp 0", osrc4); end
        tick();
        checks++; if (osrc4 !== 2'd3) begin errors++; $display("FAIL wrap_src3 got %0d exp 3", osrc4); end
        vld4 = 4'h0;
        tick();
        checks++; if (ovld4 !== 1'b0) begin errors++; $display("FAIL skip_drain got %b exp 0", ovld4); end
    endtask

    task automatic test_backpressure();
        vld4 = 4'hF;
        tick();
        checks++; if (osrc4 !== 2'd0 || odata4 !== 32'hA0) begin errors++; $display("FAIL bp_load got %0d/%h exp 0/a0", osrc4, odata4); end
        ordy4 = 1'b0;
        #1;
        checks++; if (rdy4 !== 4'b0000) begin errors++; $display("FAIL bp_ready got %b exp 0000", rdy4); end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (odata4 !== 32'hA0 || osrc4 !== 2'd0 || ovld4 !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d] got %h/%0d/%b exp a0/0/1", k, odata4, osrc4, ovld4); end
        end
        checks++; if (stall4 !== 16'd5) begin errors++; $display("FAIL bp_stall got %0d exp 5", stall4); end
        checks++; if (rdy4 !== 4'b0000) begin errors++; $display("FAIL bp_ready_end got %b exp 0000", rdy4); end
        ordy4 = 1'b1;
        #1;
        checks++; if (rdy4 !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b exp 0010", rdy4); end
        tick();
        checks++; if (ovld4 !== 1'b1 || odata4 !== 32'hA1 || osrc4 !== 2'd1) begin errors++; $display("FAIL bp_reload got %b/%h/%0d exp 1/a1/1", ovld4, odata4, osrc4); end
        checks++; if (stall4 !== 16'd5) begin errors++; $display("FAIL bp_stall_hold got %0d exp 5", stall4); end
        vld4 = 4'h0;
        tick();
        checks++; if (ovld4 !== 1'b0 || odata4 !== 32'hA1 || osrc4 !== 2'd1) begin errors++; $display("FAIL bp_drain got %b/%h/%0d exp 0/a1/1", ovld4, odata4, osrc4); end
    endtask

    task automatic test_forced();
        mode4 = 1'b1; fsel4 = 2'd2; vld4 = 4'hF;
        #1;
        checks++; if (rdy4 !== 4'b0100) begin errors++; $display("FAIL force_ready got %b exp 0100", rdy4); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (osrc4 !== 2'd2 || odata4 !== 32'hA2) begin errors++; $display("FAIL force_src[%0d] got %0d/%h exp 2/a2", k, osrc4, odata4); end
        end
        mode4 = 1'b0;
        #1;
        checks++; if (rdy4 !== 4'b0100) begin errors++; $display("FAIL force_ptr_kept got %b exp 0100", rdy4); end
        tick();
        checks++; if (osrc4 !== 2'd2) begin errors++; $display("FAIL force_rr_resume got %0d exp 2", osrc4); end
        vld4 = 4'h0;
        tick();
    endtask

    task automatic test_reset_mid();
        vld4 = 4'b0001;
        tick();
        checks++; if (osrc4 !== 2'd0) begin errors++; $display("FAIL mid_pre got %0d exp 0", osrc4); end
        ordy4 = 1'b0; vld4 = 4'hF;
        tick();
        checks++; if (ovld4 !== 1'b1) begin errors++; $display("FAIL mid_held got %b exp 1", ovld4); end
        rst4 = 1'b1;
        tick();
        checks++; if (ovld4 !== 1'b0 || odata4 !== 32'h0 || osrc4 !== 2'd0) begin errors++; $display("FAIL mid_regs got %b/%h/%0d exp 0/0/0", ovld4, odata4, osrc4); end
        checks++; if (stall4 !== 16'd0) begin errors++; $display("FAIL mid_stall got %0d exp 0", stall4); end
        checks++; if (rdy4 !== 4'b0000) begin errors++; $display("FAIL mid_ready got %b exp 0000", rdy4); end
        rst4 = 1'b0; ordy4 = 1'b1;
        #1;
        checks++; if (rdy4 !== 4'b0001) begin errors++; $display("FAIL mid_ptr got %b exp 0001", rdy4); end
        tick();
        checks++; if (ovld4 !== 1'b1 || odata4 !== 32'hA0) begin errors++; $display("FAIL mid_resume got %b/%h exp 1/a0", ovld4, odata4); end
        vld4 = 4'h0;
    endtask

    task automatic test_n3();
        rst3 = 1'b0; mode3 = 1'b0; vld3 = 3'b111; ordy3 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (osrc3 !== 2'(k % 3) || odata3 !== 8'h30 + 8'(k % 3)) begin errors++; $display("FAIL n3_seq[%0d] got %0d/%h exp %0d/%h", k, osrc3, odata3, k % 3, 8'h30 + 8'(k % 3)); end
        end
        mode3 = 1'b1; fsel3 = 2'd1;
        #1;
        checks++; if (rdy3 !== 3'b010) begin errors++; $display("FAIL n3_force1 got %b exp 010", rdy3); end
        fsel3 = 2'd3;
        #1;
        checks++; if (rdy3 !== 3'b000) begin errors++; $display("FAIL n3_force_oor got %b exp 000", rdy3); end
        tick();
        checks++; if (ovld3 !== 1'b0) begin errors++; $display("FAIL n3_oor_drain got %b exp 0", ovld3); end
        tick();
        checks++; if (ovld3 !== 1'b0 || osrc3 !== 2'd2) begin errors++; $display("FAIL n3_oor_idle got %b/%0d exp 0/2", ovld3, osrc3); end
    endtask

    initial begin
        rst4 = 1'b1; mode4 = 1'b0; ordy4 = 1'b1; fsel4 = 2'd0; vld4 = 4'h0;
        data4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        rst3 = 1'b1; mode3 = 1'b0; ordy3 = 1'b1; fsel3 = 2'd0; vld3 = 3'b0;
        data3 = {8'h32, 8'h31, 8'h30};
        test_reset();
        test_rr_stream();
        test_skip_wrap();
        test_backpressure();
        test_forced();
        test_reset_mid();
        test_n3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
